// File: rtl/cpu.sv
// 8-bit single-cycle RISC core: combinational controller8 decode feeding a
// datapath8 that holds the register file, zero flag and program counter.

package cpu_pkg;
   typedef enum logic [2:0] {
      ALU_PASSB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
   } alu_op_e;
   typedef enum logic [1:0] {ADDR_IMM, ADDR_RD, ADDR_RS} addr_src_e;
   typedef enum logic [1:0] {PC_INC1, PC_INC2, PC_IMM, PC_HOLD} pc_src_e;
endpackage

module controller8
   import cpu_pkg::*;
(
   input  logic [3:0] op,
   input  logic [1:0] cond,
   input  logic       sh_right,
   input  logic       z,
   output logic       reg_wr,
   output logic       z_wr,
   output alu_op_e    alu_op,
   output logic       alu_src,
   output logic       mem_to_reg,
   output logic       mem_wr,
   output addr_src_e  addr_src,
   output pc_src_e    pc_src
);
   logic taken_s;

   // branch condition from the rd field
   always_comb begin
      taken_s = 1'b1;
      case (cond)
         2'b01:   taken_s = z;
         2'b10:   taken_s = ~z;
         default: taken_s = 1'b1;
      endcase
   end

   // opcode decode
   always_comb begin
      reg_wr     = 1'b0;
      z_wr       = 1'b0;
      alu_op     = ALU_PASSB;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      mem_wr     = 1'b0;
      addr_src   = ADDR_IMM;
      pc_src     = PC_INC1;
      case (op)
         4'h0: pc_src = PC_INC1;
         4'h1: reg_wr = 1'b1;
         4'h2: begin reg_wr = 1'b1; z_wr = 1'b1; alu_op = ALU_ADD; end
         4'h3: begin reg_wr = 1'b1; z_wr = 1'b1; alu_op = ALU_SUB; end
         4'h4: begin reg_wr = 1'b1; z_wr = 1'b1; alu_op = ALU_AND; end
         4'h5: begin reg_wr = 1'b1; z_wr = 1'b1; alu_op = ALU_OR;  end
         4'h6: begin reg_wr = 1'b1; z_wr = 1'b1; alu_op = ALU_XOR; end
         4'h7: begin
            reg_wr = 1'b1;
            z_wr   = 1'b1;
            alu_op = sh_right ? ALU_SHR : ALU_SHL;
         end
         4'h8: begin reg_wr = 1'b1; alu_src = 1'b1; pc_src = PC_INC2; end
         4'h9: begin
            reg_wr  = 1'b1;
            z_wr    = 1'b1;
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
            pc_src  = PC_INC2;
         end
         4'hA: begin reg_wr = 1'b1; mem_to_reg = 1'b1; addr_src = ADDR_RS; end
         4'hB: begin mem_wr = 1'b1; addr_src = ADDR_RD; end
         4'hC: begin reg_wr = 1'b1; mem_to_reg = 1'b1; pc_src = PC_INC2; end
         4'hD: begin mem_wr = 1'b1; pc_src = PC_INC2; end
         4'hE: pc_src = taken_s ? PC_IMM : PC_INC2;
         4'hF: pc_src = PC_HOLD;
         default: pc_src = PC_INC1;
      endcase
   end
endmodule

module datapath8
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] instr,
   input  logic [7:0] imm,
   input  logic [7:0] mem_rd_data,
   input  logic       reg_wr,
   input  logic       z_wr,
   input  alu_op_e    alu_op,
   input  logic       alu_src,
   input  logic       mem_to_reg,
   input  addr_src_e  addr_src,
   input  pc_src_e    pc_src,
   output logic       z,
   output logic [7:0] pc,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wr_data
);
   logic [7:0] rf_q [4];
   logic [7:0] rf_d [4];
   logic       z_q, z_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] rd_val_s, rs_val_s, alu_b_s, alu_y_s, wb_s;

   assign rd_val_s    = rf_q[instr[3:2]];
   assign rs_val_s    = rf_q[instr[1:0]];
   assign alu_b_s     = alu_src ? imm : rs_val_s;
   assign wb_s        = mem_to_reg ? mem_rd_data : alu_y_s;
   assign mem_wr_data = rs_val_s;
   assign pc          = pc_q;
   assign z           = z_q;

   // ALU; the register file is read before the edge so rd==rs sees the old value
   always_comb begin
      alu_y_s = 8'h00;
      case (alu_op)
         ALU_PASSB: alu_y_s = alu_b_s;
         ALU_ADD:   alu_y_s = rd_val_s + alu_b_s;
         ALU_SUB:   alu_y_s = rd_val_s - alu_b_s;
         ALU_AND:   alu_y_s = rd_val_s & alu_b_s;
         ALU_OR:    alu_y_s = rd_val_s | alu_b_s;
         ALU_XOR:   alu_y_s = rd_val_s ^ alu_b_s;
         ALU_SHL:   alu_y_s = {rd_val_s[6:0], 1'b0};
         ALU_SHR:   alu_y_s = {1'b0, rd_val_s[7:1]};
         default:   alu_y_s = 8'h00;
      endcase
   end

   // data RAM address select
   always_comb begin
      mem_addr = imm;
      case (addr_src)
         ADDR_RD:  mem_addr = rd_val_s;
         ADDR_RS:  mem_addr = rs_val_s;
         default:  mem_addr = imm;
      endcase
   end

   // next-state for registers, flag and program counter
   always_comb begin
      rf_d = rf_q;
      if (reg_wr) begin
         rf_d[instr[3:2]] = wb_s;
      end else begin
         rf_d = rf_q;
      end
      if (z_wr) begin
         z_d = (alu_y_s == 8'h00);
      end else begin
         z_d = z_q;
      end
      pc_d = pc_q + 8'd1;
      case (pc_src)
         PC_INC1: pc_d = pc_q + 8'd1;
         PC_INC2: pc_d = pc_q + 8'd2;
         PC_IMM:  pc_d = imm;
         PC_HOLD: pc_d = pc_q;
         default: pc_d = pc_q + 8'd1;
      endcase
   end

   // architectural state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_q <= '{default: 8'h00};
         z_q  <= 1'b0;
         pc_q <= 8'h00;
      end else begin
         rf_q <= rf_d;
         z_q  <= z_d;
         pc_q <= pc_d;
      end
   end
endmodule

module cpu
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic [7:0] imm,
   output logic [7:0] pc,
   output logic [7:0] mem_addr,
   output logic       mem_wr,
   output logic [7:0] mem_wr_data,
   input  logic [7:0] mem_rd_data
);
   logic      reg_wr_s, z_wr_s, alu_src_s, mem_to_reg_s, mem_wr_s, z_s;
   alu_op_e   alu_op_s;
   addr_src_e addr_src_s;
   pc_src_e   pc_src_s;

   controller8 u_ctrl (
      .op(instr[7:4]), .cond(instr[3:2]), .sh_right(instr[0]), .z(z_s),
      .reg_wr(reg_wr_s), .z_wr(z_wr_s), .alu_op(alu_op_s), .alu_src(alu_src_s),
      .mem_to_reg(mem_to_reg_s), .mem_wr(mem_wr_s), .addr_src(addr_src_s),
      .pc_src(pc_src_s)
   );

   datapath8 u_dp (
      .clk(clk), .rst_n(rst), .instr(instr), .imm(imm), .mem_rd_data(mem_rd_data),
      .reg_wr(reg_wr_s), .z_wr(z_wr_s), .alu_op(alu_op_s), .alu_src(alu_src_s),
      .mem_to_reg(mem_to_reg_s), .addr_src(addr_src_s), .pc_src(pc_src_s),
      .z(z_s), .pc(pc), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data)
   );

   // a store in flight must not reach the RAM while reset is held
   assign mem_wr = mem_wr_s & rst;
endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: an ISA-level interpreter predicts pc and memory
// bus activity per cycle; a negedge monitor compares against the DUT.
module tb_cpu;
   logic       clk, rst;
   logic [7:0] instr, imm, pc, mem_addr, mem_wr_data, mem_rd_data, pc_p1;
   logic       mem_wr;

   logic [7:0] imem [256];
   logic [7:0] ram  [256];
   logic [7:0] port_q [$];

   typedef struct packed {
      logic [7:0] pc;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;
   exp_t sb [$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   bit running = 1'b0;

   // reference model state
   logic [7:0] m_r [4];
   logic       m_z;
   logic [7:0] m_pc;
   logic [7:0] m_mem [256];

   cpu dut (
      .clk(clk), .rst(rst), .instr(instr), .imm(imm), .pc(pc),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign pc_p1       = pc + 8'd1;
   assign instr       = imem[pc];
   assign imm         = imem[pc_p1];
   assign mem_rd_data = ram[mem_addr];

   always @(posedge clk) begin
      if (mem_wr) begin
         ram[mem_addr] <= mem_wr_data;
         if (mem_addr == 8'hFF) port_q.push_back(mem_wr_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (running) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
         end else begin
            mon_e = sb.pop_front();
            chk("pc", pc, mon_e.pc);
            chk("mem_wr", mem_wr, mon_e.wr);
            chk("mem_addr", mem_addr, mon_e.addr);
            chk("mem_wr_data", mem_wr_data, mon_e.data);
         end
      end
   end

   // Executes one instruction at ISA level; reports the bus activity expected
   // during that instruction's cycle.
   task automatic model_step(output exp_t e);
      logic [7:0] ins, im, a, b, res, npc;
      logic [1:0] rd, rs;
      logic       taken;
      ins = imem[m_pc];
      im  = imem[m_pc + 8'd1];
      rd  = ins[3:2];
      rs  = ins[1:0];
      a   = m_r[rd];
      b   = m_r[rs];
      e.pc = m_pc; e.wr = 1'b0; e.addr = im; e.data = b;
      npc = m_pc + 8'd1;
      res = 8'h00;
      case (ins[7:4])
         4'h1: m_r[rd] = b;
         4'h2: begin res = a + b; m_r[rd] = res; m_z = (res == 8'h00); end
         4'h3: begin res = a - b; m_r[rd] = res; m_z = (res == 8'h00); end
         4'h4: begin res = a & b; m_r[rd] = res; m_z = (res == 8'h00); end
         4'h5: begin res = a | b; m_r[rd] = res; m_z = (res == 8'h00); end
         4'h6: begin res = a ^ b; m_r[rd] = res; m_z = (res == 8'h00); end
         4'h7: begin
            res = ins[0] ? (a >> 1) : (a << 1);
            m_r[rd] = res; m_z = (res == 8'h00);
         end
         4'h8: begin m_r[rd] = im; npc = m_pc + 8'd2; end
         4'h9: begin res = a + im; m_r[rd] = res; m_z = (res == 8'h00); npc = m_pc + 8'd2; end
         4'hA: begin e.addr = b; m_r[rd] = m_mem[b]; end
         4'hB: begin e.addr = a; e.wr = 1'b1; m_mem[a] = b; end
         4'hC: begin m_r[rd] = m_mem[im]; npc = m_pc + 8'd2; end
         4'hD: begin e.wr = 1'b1; m_mem[im] = b; npc = m_pc + 8'd2; end
         4'hE: begin
            taken = (rd == 2'd1) ? m_z : (rd == 2'd2) ? !m_z : 1'b1;
            npc = taken ? im : m_pc + 8'd2;
         end
         4'hF: npc = m_pc;
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_z = 1'b0;
      m_pc = 8'h00;
      for (int i = 0; i < 256; i++) m_mem[i] = ram[i];
   endtask

   task automatic step();
      exp_t e;
      model_step(e);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Holds reset across edges, checks reset outputs, restarts model and DUT.
   task automatic do_reset(input bit rand_ram);
      running = 1'b0;
      rst = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pc", pc, 8'h00);
      chk("reset_mem_wr", mem_wr, 1'b0);
      for (int i = 0; i < 256; i++) ram[i] = rand_ram ? 8'($urandom) : 8'h00;
      port_q.delete();
      model_reset();
      rst = 1'b1;
      running = 1'b1;
   endtask

   task automatic load(input logic [7:0] fill, input logic [7:0] base, input logic [7:0] p [$]);
      for (int i = 0; i < 256; i++) imem[i] = fill;
      for (int i = 0; i < p.size(); i++) imem[8'(base + i)] = p[i];
   endtask

   task automatic check_port(input string name, input logic [7:0] ex [$]);
      chk({name, "_count"}, port_q.size(), ex.size());
      for (int i = 0; i < ex.size(); i++) begin
         if (i < port_q.size()) chk(name, port_q[i], ex[i]);
      end
   endtask

   initial begin
      exp_t e;
      rst = 1'b0;
      for (int i = 0; i < 256; i++) begin imem[i] = 8'h00; ram[i] = 8'h00; end

      // reset, then NOPs step pc by one
      load(8'h00, 8'h00, '{8'h00});
      do_reset(1'b0);
      run(2);
      chk("nop_pc", pc, 8'h02);

      // LI/LI/ADD/STI to the output port
      load(8'hF0, 8'h00, '{8'h84, 8'h05, 8'h88, 8'h03, 8'h26, 8'hD1, 8'hFF, 8'hF0});
      do_reset(1'b0);
      run(7);
      check_port("add_port", '{8'h08});
      chk("add_halt_pc", pc, 8'h07);

      // wrap to zero, Z-taken branches, logical right shift, SUB self
      load(8'hF0, 8'h00, '{8'h80, 8'hFF, 8'h90, 8'h01, 8'hE4, 8'h08, 8'hF0, 8'hF0,
                           8'hD0, 8'hFF, 8'h84, 8'h81, 8'h75, 8'hD1, 8'hFF, 8'h35,
                           8'hE4, 8'h14, 8'hF0, 8'hF0, 8'hD1, 8'hFF, 8'hF0});
      do_reset(1'b0);
      run(13);
      check_port("flag_port", '{8'h00, 8'h40, 8'h00});
      chk("flag_halt_pc", pc, 8'h16);

      // store then load through a register address
      load(8'hF0, 8'h00, '{8'h8C, 8'h10, 8'h84, 8'hAA, 8'hBD, 8'hAB, 8'hD2, 8'hFF, 8'hF0});
      do_reset(1'b0);
      run(8);
      check_port("mem_port", '{8'hAA});
      chk("mem_ram10", ram[8'h10], 8'hAA);

      // BNZ loop counting down from 3, then HALT freezes pc
      load(8'hF0, 8'h00, '{8'h80, 8'h03, 8'h90, 8'hFF, 8'hE8, 8'h02, 8'hD0, 8'hFF, 8'hF0});
      do_reset(1'b0);
      run(14);
      check_port("loop_port", '{8'h00});
      chk("loop_halt_pc", pc, 8'h08);

      // pc wraps from 0xFF to 0x00
      load(8'h00, 8'h00, '{8'hE0, 8'hFE});
      do_reset(1'b0);
      run(6);

      // reset asserted in the middle of a store cycle
      load(8'hF0, 8'h00, '{8'hD1, 8'hFF, 8'h84, 8'h77, 8'h88, 8'h20, 8'hB9,
                           8'hD1, 8'hFF, 8'hF0});
      do_reset(1'b0);
      run(3);
      model_step(e);
      sb.push_back(e);
      @(negedge clk);
      #1;
      running = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_mem_wr", mem_wr, 1'b0);
      chk("midrst_pc", pc, 8'h00);
      @(posedge clk);
      #1;
      chk("midrst_ram20", ram[8'h20], 8'h00);
      sb.delete();
      model_reset();
      rst = 1'b1;
      running = 1'b1;
      run(6);
      check_port("midrst_port", '{8'h00, 8'h00, 8'h77});
      chk("midrst_ram20_after", ram[8'h20], 8'h77);

      // random programs against the interpreter
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 256; i++) begin
            imem[i] = 8'($urandom);
            if (imem[i][7:4] == 4'hF && $urandom_range(0, 7) != 0)
               imem[i][7:4] = 4'($urandom_range(0, 14));
         end
         do_reset(1'b1);
         run(60);
      end

      running = 1'b0;
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
